// File: rtl/array_reverse_pkg.sv
// Shared definitions for the in-place array reversal engine: default
// address/data widths matching the array memory and the FSM state encoding.
package array_reverse_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_LO = 3'd1;
    localparam logic [2:0] ST_RD_HI = 3'd2;
    localparam logic [2:0] ST_WR_LO = 3'd3;
    localparam logic [2:0] ST_WR_HI = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/array_reverse.sv
// In-place reversal of elements [0, len-1] of an external array memory.
// A job arrives on the in_ handshake, each swap pair costs read/read/write/write
// on the arr_ port, and the number of swapped pairs is reported on out_.
module array_reverse
    import array_reverse_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW:0]   in_len,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_swaps,
    output logic          arr_valid,
    input  logic          arr_ready,
    output logic [AW-1:0] arr_addr,
    output logic          arr_we,
    output logic [DW-1:0] arr_di,
    input  logic [DW-1:0] arr_do
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] TWO   = {{(AW-1){1'b0}}, 2'b10};

    logic [2:0]    state_q, state_d;
    logic [AW:0]   lo_q, lo_d;
    logic [AW:0]   hi_q, hi_d;
    logic [DW-1:0] tmp_lo_q, tmp_lo_d;
    logic [DW-1:0] tmp_hi_q, tmp_hi_d;
    logic [AW-1:0] swaps_q, swaps_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] di_q;

    logic [AW:0]   len_clamped;
    logic [AW:0]   lo_inc;
    logic [AW:0]   hi_dec;
    logic          fire;

    // Lengths beyond the memory depth are treated as a full-array reversal;
    // hi never wraps below zero so the pointer compare cannot glitch.
    assign len_clamped = (in_len > DEPTH) ? DEPTH : in_len;
    assign lo_inc      = lo_q + ONE;
    assign hi_dec      = (hi_q == '0) ? hi_q : (hi_q - ONE);
    assign fire        = arr_valid & arr_ready;

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign out_swaps   = swaps_q;

    // Memory port drive: address/data follow the access state, and outside
    // access states they hold whatever was last presented to the memory.
    always_comb begin
        arr_valid = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = addr_q;
        arr_di    = di_q;
        case (state_q)
            ST_RD_LO: begin
                arr_valid = 1'b1;
                arr_addr  = lo_q[AW-1:0];
            end
            ST_RD_HI: begin
                arr_valid = 1'b1;
                arr_addr  = hi_q[AW-1:0];
            end
            ST_WR_LO: begin
                arr_valid = 1'b1;
                arr_we    = 1'b1;
                arr_addr  = lo_q[AW-1:0];
                arr_di    = tmp_hi_q;
            end
            ST_WR_HI: begin
                arr_valid = 1'b1;
                arr_we    = 1'b1;
                arr_addr  = hi_q[AW-1:0];
                arr_di    = tmp_lo_q;
            end
            default: begin
            end
        endcase
    end

    // Sequencing: every access state waits for the memory to accept before
    // moving on, so a stalled access is simply repeated with identical outputs.
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        tmp_lo_d = tmp_lo_q;
        tmp_hi_d = tmp_hi_q;
        swaps_d  = swaps_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    lo_d    = '0;
                    hi_d    = (len_clamped == '0) ? '0 : (len_clamped - ONE);
                    swaps_d = '0;
                    state_d = (len_clamped < TWO) ? ST_DONE : ST_RD_LO;
                end
            end
            ST_RD_LO: begin
                if (fire) begin
                    tmp_lo_d = arr_do;
                    state_d  = ST_RD_HI;
                end
            end
            ST_RD_HI: begin
                if (fire) begin
                    tmp_hi_d = arr_do;
                    state_d  = ST_WR_LO;
                end
            end
            ST_WR_LO: begin
                if (fire) begin
                    state_d = ST_WR_HI;
                end
            end
            ST_WR_HI: begin
                if (fire) begin
                    swaps_d = swaps_q + {{(AW-1){1'b0}}, 1'b1};
                    lo_d    = lo_inc;
                    hi_d    = hi_dec;
                    state_d = (lo_inc >= hi_dec) ? ST_DONE : ST_RD_LO;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any job on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            tmp_lo_q <= '0;
            tmp_hi_q <= '0;
            swaps_q  <= '0;
            addr_q   <= '0;
            di_q     <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            tmp_lo_q <= tmp_lo_d;
            tmp_hi_q <= tmp_hi_d;
            swaps_q  <= swaps_d;
            addr_q   <= arr_addr;
            di_q     <= arr_di;
        end
    end

endmodule

// File: tb/tb_array_reverse.sv
// Self-checking bench for array_reverse: an array memory model, a per-cycle
// access checker fed by a reference model of the reversal, and directed plus
// randomized jobs.
module tb_array_reverse;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 16;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          we;
      logic [DW-1:0] di;
   } access_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [AW:0]   in_len;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_swaps;
   logic          arr_valid;
   logic          arr_ready;
   logic [AW-1:0] arr_addr;
   logic          arr_we;
   logic [DW-1:0] arr_di;
   logic [DW-1:0] arr_do;

   logic [DW-1:0] mem [DEPTH];
   access_t       expQ [$];

   int totalChecks  = 0;
   int failChecks   = 0;
   int accCount     = 0;
   int memInitMode  = 0;
   bit monitorOn    = 1'b0;
   bit randomReady  = 1'b0;
   bit holdReadyLow = 1'b0;

   // Free-running clock
   always #5 clock = ~clock;

   array_reverse dut (
      .clk       (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_len    (in_len),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_swaps (out_swaps),
      .arr_valid (arr_valid),
      .arr_ready (arr_ready),
      .arr_addr  (arr_addr),
      .arr_we    (arr_we),
      .arr_di    (arr_di),
      .arr_do    (arr_do)
   );

   // Array memory: combinational read, write on an accepted write access
   assign arr_do = mem[arr_addr];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         failChecks++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clock);
      #2;
   endtask

   // Memory update and (re)initialisation on the active edge
   initial begin
      forever begin
         @(posedge clock);
         if (memInitMode == 1) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i);
         end else if (memInitMode == 2) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom;
         end else if (arr_valid && arr_ready) begin
            accCount++;
            if (arr_we) mem[arr_addr] <= arr_di;
         end
      end
   end

   // Memory ready drive and per-cycle access checker against expected queue
   initial begin
      access_t exp;
      arr_ready = 1'b1;
      forever begin
         @(negedge clock);
         if (holdReadyLow) arr_ready = 1'b0;
         else if (randomReady) arr_ready = 1'($urandom_range(0, 1));
         else arr_ready = 1'b1;
         if (monitorOn) begin
            if (arr_valid) begin
               checkOutput("access_expected", 64'(expQ.size() > 0), 64'd1);
               if (expQ.size() > 0) begin
                  exp = expQ[0];
                  checkOutput("arr_addr", 64'(arr_addr), 64'(exp.addr));
                  checkOutput("arr_we", 64'(arr_we), 64'(exp.we));
                  if (exp.we) checkOutput("arr_di", 64'(arr_di), 64'(exp.di));
                  if (arr_ready) void'(expQ.pop_front());
               end
            end else begin
               checkOutput("arr_we_idle", 64'(arr_we), 64'd0);
            end
         end
      end
   end

   task automatic initMemory(input int mode);
      memInitMode = mode;
      stepCycle();
      memInitMode = 0;
   endtask

   // Load the expected access sequence for a reversal of len elements
   task automatic buildModel(input int len, output int pairs, output logic [DW-1:0] old [DEPTH]);
      int L;
      access_t a;
      L = (len > DEPTH) ? DEPTH : len;
      pairs = L / 2;
      for (int i = 0; i < DEPTH; i++) old[i] = mem[i];
      expQ.delete();
      for (int p = 0; p < pairs; p++) begin
         a.addr = AW'(p);         a.we = 1'b0; a.di = '0;             expQ.push_back(a);
         a.addr = AW'(L - 1 - p); a.we = 1'b0; a.di = '0;             expQ.push_back(a);
         a.addr = AW'(p);         a.we = 1'b1; a.di = old[L - 1 - p]; expQ.push_back(a);
         a.addr = AW'(L - 1 - p); a.we = 1'b1; a.di = old[p];         expQ.push_back(a);
      end
   endtask

   // Run one job end to end and compare results against the model
   task automatic applyStimulus(input int len, input bit rnd, input bit holdOut);
      int L, pairs, lat, startAcc;
      logic [DW-1:0] old [DEPTH];
      L = (len > DEPTH) ? DEPTH : len;
      buildModel(len, pairs, old);
      randomReady = rnd;
      monitorOn   = 1'b1;
      out_ready   = !holdOut;
      startAcc    = accCount;
      checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
      in_len   = 5'(len);
      in_valid = 1'b1;
      stepCycle();
      lat      = 1;
      in_valid = 1'b0;
      in_len   = 5'($urandom_range(0, 31));
      while (!out_valid && lat < 400) begin
         stepCycle();
         lat++;
      end
      checkOutput("out_valid_seen", 64'(out_valid), 64'd1);
      if (!rnd) checkOutput("latency", 64'(lat), 64'((pairs == 0) ? 1 : 4 * pairs + 1));
      checkOutput("out_swaps", 64'(out_swaps), 64'(pairs));
      checkOutput("access_count", 64'(accCount - startAcc), 64'(4 * pairs));
      if (holdOut) begin
         for (int c = 0; c < 10; c++) begin
            checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_out_swaps", 64'(out_swaps), 64'(pairs));
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
            in_valid = 1'b1;
            in_len   = 5'd3;
            stepCycle();
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      stepCycle();
      checkOutput("back_to_idle", 64'(in_ready), 64'd1);
      checkOutput("out_valid_low", 64'(out_valid), 64'd0);
      stepCycle();
      checkOutput("no_access_after", 64'(arr_valid), 64'd0);
      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
      for (int i = 0; i < DEPTH; i++)
         checkOutput($sformatf("mem[%0d]", i), 64'(mem[i]), 64'((i < L) ? old[L - 1 - i] : old[i]));
      randomReady = 1'b0;
   endtask

   initial begin
      int startAcc, n;
      int pairs;
      logic [DW-1:0] old [DEPTH];

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_len    = '0;
      out_ready = 1'b1;
      memInitMode = 1;
      repeat (3) stepCycle();
      memInitMode = 0;
      reset = 1'b0;
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_swaps", 64'(out_swaps), 64'd0);
      checkOutput("rst_arr_valid", 64'(arr_valid), 64'd0);
      checkOutput("rst_arr_addr", 64'(arr_addr), 64'd0);
      checkOutput("rst_arr_di", 64'(arr_di), 64'd0);

      // Full-array reversal with the memory always ready
      applyStimulus(16, 1'b0, 1'b0);
      checkOutput("len16_mem0", 64'(mem[0]), 64'd15);
      checkOutput("len16_mem7", 64'(mem[7]), 64'd8);
      checkOutput("len16_mem15", 64'(mem[15]), 64'd0);

      // Odd length leaves the middle element and the tail alone
      initMemory(1);
      applyStimulus(5, 1'b0, 1'b0);
      checkOutput("len5_mem0", 64'(mem[0]), 64'd4);
      checkOutput("len5_mem1", 64'(mem[1]), 64'd3);
      checkOutput("len5_mem2", 64'(mem[2]), 64'd2);
      checkOutput("len5_mem4", 64'(mem[4]), 64'd0);
      checkOutput("len5_mem5", 64'(mem[5]), 64'd5);

      // Degenerate lengths
      initMemory(1);
      applyStimulus(0, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 1'b0);

      // Memory back-pressure
      initMemory(1);
      applyStimulus(16, 1'b1, 1'b0);
      checkOutput("bp_mem3", 64'(mem[3]), 64'd12);

      // Result held while the consumer stalls
      applyStimulus(4, 1'b0, 1'b1);

      // Reset during WR_LO of the third swap, then a fresh len=2 job
      initMemory(1);
      buildModel(16, pairs, old);
      monitorOn = 1'b1;
      startAcc  = accCount;
      in_len    = 5'd16;
      in_valid  = 1'b1;
      stepCycle();
      in_valid = 1'b0;
      n = 0;
      while ((accCount - startAcc) < 10 && n < 100) begin
         stepCycle();
         n++;
      end
      checkOutput("reset_point_reached", 64'(accCount - startAcc), 64'd10);
      checkOutput("reset_point_we", 64'(arr_we), 64'd1);
      checkOutput("reset_point_addr", 64'(arr_addr), 64'd2);
      monitorOn    = 1'b0;
      holdReadyLow = 1'b1;
      reset        = 1'b1;
      stepCycle();
      reset        = 1'b0;
      holdReadyLow = 1'b0;
      expQ.delete();
      checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
      checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
      checkOutput("abort_out_swaps", 64'(out_swaps), 64'd0);
      checkOutput("abort_arr_valid", 64'(arr_valid), 64'd0);
      checkOutput("abort_arr_we", 64'(arr_we), 64'd0);
      checkOutput("abort_arr_addr", 64'(arr_addr), 64'd0);
      checkOutput("abort_arr_di", 64'(arr_di), 64'd0);
      checkOutput("abort_mem1", 64'(mem[1]), 64'd14);
      checkOutput("abort_mem2", 64'(mem[2]), 64'd2);
      checkOutput("abort_mem14", 64'(mem[14]), 64'd1);
      applyStimulus(2, 1'b0, 1'b0);
      checkOutput("len2_mem0", 64'(mem[0]), 64'd14);
      checkOutput("len2_mem1", 64'(mem[1]), 64'd15);
      checkOutput("len2_mem15", 64'(mem[15]), 64'd0);

      // Randomized jobs, including over-range lengths that clamp to the depth
      for (int j = 0; j < 15; j++) begin
         if ($urandom_range(0, 2) == 0) initMemory(2);
         applyStimulus(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("%0d/%0d checks passed", totalChecks - failChecks, totalChecks);
      $finish;
   end

endmodule
